lsu: RTL and testbench

- Data-side load/store unit: the writer end of the same combinational `mem` port that instruction fetch only reads.
- Takes one load or store request from EXU over a valid/ready handshake.
- Drives the `mem` read and write port for exactly one cycle per request: aligned dword address, byte mask, shifted data.
- Returns the extended load data, or a misalign flag, over a valid/ready response.

---
 rtl/lsu.sv | 151 +++++++++++++++
 tb/tb_lsu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Data-side load/store unit: one request at a time, one mem access cycle per request,
// aligned dword address with byte mask and shifted data, extended load data on response.
module lsu #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            io_req_valid,
   output logic            io_req_ready,
   input  logic [XLEN-1:0] io_req_addr,
   input  logic [XLEN-1:0] io_req_wdata,
   input  logic            io_req_wen,
   input  logic [1:0]      io_req_size,
   input  logic            io_req_signed,
   output logic            io_resp_valid,
   input  logic            io_resp_ready,
   output logic [XLEN-1:0] io_resp_rdata,
   output logic            io_resp_misalign,
   output logic [XLEN-1:0] io_mem_Raddr,
   input  logic [XLEN-1:0] io_mem_Rdata,
   output logic [XLEN-1:0] io_mem_Waddr,
   output logic [XLEN-1:0] io_mem_Wdata,
   output logic [7:0]      io_mem_Wmask,
   output logic            io_mem_Write_en
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            wen_q, wen_d;
   logic [1:0]      size_q, size_d;
   logic            sext_q, sext_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            misalign_q, misalign_d;

   logic [2:0]      sh;
   logic [2:0]      lo_mask;
   logic [7:0]      base_mask;
   logic            misalign;
   logic [XLEN-1:0] aligned_addr;
   logic [7:0]      wmask_sh;
   logic [XLEN-1:0] wdata_sh;
   logic [XLEN-1:0] rd_sh;
   logic [XLEN-1:0] ld_ext;

   always_comb begin
      sh = addr_q[2:0];
      unique case (size_q)
         2'd0: begin lo_mask = 3'b000; base_mask = 8'h01; end
         2'd1: begin lo_mask = 3'b001; base_mask = 8'h03; end
         2'd2: begin lo_mask = 3'b011; base_mask = 8'h0F; end
         default: begin lo_mask = 3'b111; base_mask = 8'hFF; end
      endcase
      misalign     = (addr_q[2:0] & lo_mask) != 3'b000;
      aligned_addr = {addr_q[XLEN-1:3], 3'b000};
      wmask_sh     = base_mask << sh;
      wdata_sh     = wdata_q << {sh, 3'b000};
      rd_sh        = io_mem_Rdata >> {sh, 3'b000};
      unique case (size_q)
         2'd0: ld_ext = sext_q ? {{(XLEN-8){rd_sh[7]}}, rd_sh[7:0]}
                               : {{(XLEN-8){1'b0}}, rd_sh[7:0]};
         2'd1: ld_ext = sext_q ? {{(XLEN-16){rd_sh[15]}}, rd_sh[15:0]}
                               : {{(XLEN-16){1'b0}}, rd_sh[15:0]};
         2'd2: ld_ext = sext_q ? {{(XLEN-32){rd_sh[31]}}, rd_sh[31:0]}
                               : {{(XLEN-32){1'b0}}, rd_sh[31:0]};
         default: ld_ext = rd_sh;
      endcase
   end

   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      wen_d            = wen_q;
      size_d           = size_q;
      sext_d           = sext_q;
      rdata_d          = rdata_q;
      misalign_d       = misalign_q;
      io_req_ready     = 1'b0;
      io_resp_valid    = 1'b0;
      io_resp_rdata    = '0;
      io_resp_misalign = 1'b0;
      io_mem_Raddr     = '0;
      io_mem_Waddr     = '0;
      io_mem_Wdata     = '0;
      io_mem_Wmask     = 8'h00;
      io_mem_Write_en  = 1'b0;
      unique case (state_q)
         StIdle: begin
            io_req_ready = !reset;
            if (io_req_valid && !reset) begin
               addr_d  = io_req_addr;
               wdata_d = io_req_wdata;
               wen_d   = io_req_wen;
               size_d  = io_req_size;
               sext_d  = io_req_signed;
               state_d = StAccess;
            end
         end
         StAccess: begin
            // Reset in this cycle must not leak a partial store onto the mem port.
            if (!reset) begin
               io_mem_Raddr = aligned_addr;
               io_mem_Waddr = aligned_addr;
               if (wen_q && !misalign) begin
                  io_mem_Wmask    = wmask_sh;
                  io_mem_Wdata    = wdata_sh;
                  io_mem_Write_en = 1'b1;
               end
            end
            rdata_d    = (wen_q || misalign) ? '0 : ld_ext;
            misalign_d = misalign;
            state_d    = StResp;
         end
         StResp: begin
            if (!reset) begin
               io_resp_valid    = 1'b1;
               io_resp_rdata    = rdata_q;
               io_resp_misalign = misalign_q;
            end
            if (io_resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         wdata_q    <= '0;
         wen_q      <= 1'b0;
         size_q     <= 2'd0;
         sext_q     <= 1'b0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wen_q      <= wen_d;
         size_q     <= size_d;
         sext_q     <= sext_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, loads, misalign, backpressure, reset mid-operation, wrap.
module tb_lsu;

   logic        clock = 1'b0;
   logic        reset;
   logic        io_req_valid;
   logic        io_req_ready;
   logic [63:0] io_req_addr;
   logic [63:0] io_req_wdata;
   logic        io_req_wen;
   logic [1:0]  io_req_size;
   logic        io_req_signed;
   logic        io_resp_valid;
   logic        io_resp_ready;
   logic [63:0] io_resp_rdata;
   logic        io_resp_misalign;
   logic [63:0] io_mem_Raddr;
   logic [63:0] io_mem_Rdata;
   logic [63:0] io_mem_Waddr;
   logic [63:0] io_mem_Wdata;
   logic [7:0]  io_mem_Wmask;
   logic        io_mem_Write_en;

   int n_pass = 0;
   int n_total = 0;

   lsu #(.XLEN(64)) dut (
      .clock            (clock),
      .reset            (reset),
      .io_req_valid     (io_req_valid),
      .io_req_ready     (io_req_ready),
      .io_req_addr      (io_req_addr),
      .io_req_wdata     (io_req_wdata),
      .io_req_wen       (io_req_wen),
      .io_req_size      (io_req_size),
      .io_req_signed    (io_req_signed),
      .io_resp_valid    (io_resp_valid),
      .io_resp_ready    (io_resp_ready),
      .io_resp_rdata    (io_resp_rdata),
      .io_resp_misalign (io_resp_misalign),
      .io_mem_Raddr     (io_mem_Raddr),
      .io_mem_Rdata     (io_mem_Rdata),
      .io_mem_Waddr     (io_mem_Waddr),
      .io_mem_Wdata     (io_mem_Wdata),
      .io_mem_Wmask     (io_mem_Wmask),
      .io_mem_Write_en  (io_mem_Write_en)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Sample well after the edge, long before the next one.
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Present a request for one edge, then scramble req_* to prove they are latched.
   task automatic issue(input logic [63:0] a, input logic [63:0] d, input logic w,
                        input logic [1:0] s, input logic sg);
      io_req_valid  = 1'b1;
      io_req_addr   = a;
      io_req_wdata  = d;
      io_req_wen    = w;
      io_req_size   = s;
      io_req_signed = sg;
      tick();
      io_req_valid  = 1'b0;
      io_req_addr   = 64'hDEAD_BEEF_DEAD_BEEF;
      io_req_wdata  = 64'h5A5A_5A5A_5A5A_5A5A;
      io_req_size   = 2'd3;
      io_req_wen    = ~w;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      io_req_valid = 1'b0; io_req_addr = '0; io_req_wdata = '0; io_req_wen = 1'b0;
      io_req_size = 2'd0; io_req_signed = 1'b0; io_resp_ready = 1'b0; io_mem_Rdata = '0;

      tick();
      chk("rst_req_ready", {63'b0, io_req_ready}, 64'd0);
      chk("rst_resp_valid", {63'b0, io_resp_valid}, 64'd0);
      chk("rst_wen", {63'b0, io_mem_Write_en}, 64'd0);
      chk("rst_waddr", io_mem_Waddr, 64'd0);
      reset = 1'b0;
      #1;
      chk("idle_req_ready", {63'b0, io_req_ready}, 64'd1);

      // Store dword
      issue(64'h8000_0008, 64'h1122_3344_5566_7788, 1'b1, 2'd3, 1'b0);
      chk("sd_req_ready", {63'b0, io_req_ready}, 64'd0);
      chk("sd_waddr", io_mem_Waddr, 64'h8000_0008);
      chk("sd_raddr", io_mem_Raddr, 64'h8000_0008);
      chk("sd_wmask", {56'b0, io_mem_Wmask}, 64'hFF);
      chk("sd_wdata", io_mem_Wdata, 64'h1122_3344_5566_7788);
      chk("sd_wen", {63'b0, io_mem_Write_en}, 64'd1);
      chk("sd_resp_early", {63'b0, io_resp_valid}, 64'd0);
      tick();
      io_resp_ready = 1'b1;
      #1;
      chk("sd_resp_valid", {63'b0, io_resp_valid}, 64'd1);
      chk("sd_rdata", io_resp_rdata, 64'd0);
      chk("sd_misalign", {63'b0, io_resp_misalign}, 64'd0);
      chk("sd_wen_resp", {63'b0, io_mem_Write_en}, 64'd0);
      tick();
      io_resp_ready = 1'b0;
      #1;
      chk("sd_back_idle", {63'b0, io_req_ready}, 64'd1);

      // Store byte
      issue(64'h8000_0003, 64'h0000_0000_0000_00AB, 1'b1, 2'd0, 1'b0);
      chk("sb_waddr", io_mem_Waddr, 64'h8000_0000);
      chk("sb_wmask", {56'b0, io_mem_Wmask}, 64'h08);
      chk("sb_wdata", io_mem_Wdata, 64'h0000_0000_AB00_0000);
      chk("sb_wen", {63'b0, io_mem_Write_en}, 64'd1);
      tick();
      chk("sb_wen_once", {63'b0, io_mem_Write_en}, 64'd0);
      io_resp_ready = 1'b1;
      tick();
      io_resp_ready = 1'b0;

      // Load byte signed, then unsigned
      io_mem_Rdata = 64'h0000_8000_0000_0000;
      issue(64'h8000_0005, 64'h0, 1'b0, 2'd0, 1'b1);
      chk("lbs_raddr", io_mem_Raddr, 64'h8000_0000);
      chk("lbs_wen", {63'b0, io_mem_Write_en}, 64'd0);
      chk("lbs_wmask", {56'b0, io_mem_Wmask}, 64'h00);
      tick();
      chk("lbs_rdata", io_resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      io_resp_ready = 1'b1;
      tick();
      io_resp_ready = 1'b0;
      issue(64'h8000_0005, 64'h0, 1'b0, 2'd0, 1'b0);
      tick();
      chk("lbu_rdata", io_resp_rdata, 64'h0000_0000_0000_0080);
      io_resp_ready = 1'b1;
      tick();
      io_resp_ready = 1'b0;

      // Misaligned store word
      issue(64'h8000_0002, 64'hFFFF_FFFF, 1'b1, 2'd2, 1'b0);
      chk("mis_wen", {63'b0, io_mem_Write_en}, 64'd0);
      chk("mis_wmask", {56'b0, io_mem_Wmask}, 64'h00);
      tick();
      chk("mis_flag", {63'b0, io_resp_misalign}, 64'd1);
      chk("mis_rdata", io_resp_rdata, 64'd0);
      chk("mis_wen_resp", {63'b0, io_mem_Write_en}, 64'd0);
      io_resp_ready = 1'b1;
      tick();
      io_resp_ready = 1'b0;

      // Backpressure with a signed half load; a competing request must be ignored
      io_mem_Rdata = 64'hBEEF_0000_0000_0000;
      issue(64'h8000_0006, 64'h0, 1'b0, 2'd1, 1'b1);
      tick();
      io_mem_Rdata  = 64'h0123_4567_89AB_CDEF;
      io_req_valid  = 1'b1;
      io_req_addr   = 64'h8000_0010;
      io_req_wdata  = 64'h77;
      io_req_wen    = 1'b1;
      io_req_size   = 2'd3;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_valid", {63'b0, io_resp_valid}, 64'd1);
         chk("bp_rdata", io_resp_rdata, 64'hFFFF_FFFF_FFFF_BEEF);
         chk("bp_req_ready", {63'b0, io_req_ready}, 64'd0);
         tick();
      end
      io_req_valid  = 1'b0;
      io_resp_ready = 1'b1;
      #1;
      chk("bp_still_resp", {63'b0, io_resp_valid}, 64'd1);
      tick();
      io_resp_ready = 1'b0;
      #1;
      chk("bp_idle_ready", {63'b0, io_req_ready}, 64'd1);
      chk("bp_no_store", {63'b0, io_mem_Write_en}, 64'd0);
      chk("bp_resp_gone", {63'b0, io_resp_valid}, 64'd0);

      // Reset during the ACCESS cycle of a store
      issue(64'h8000_0020, 64'hCAFE, 1'b1, 2'd3, 1'b0);
      reset = 1'b1;
      #1;
      chk("rsta_wen", {63'b0, io_mem_Write_en}, 64'd0);
      chk("rsta_wmask", {56'b0, io_mem_Wmask}, 64'h00);
      tick();
      reset = 1'b0;
      #1;
      chk("rsta_idle", {63'b0, io_req_ready}, 64'd1);
      chk("rsta_resp", {63'b0, io_resp_valid}, 64'd0);
      chk("rsta_waddr", io_mem_Waddr, 64'd0);
      chk("rsta_raddr", io_mem_Raddr, 64'd0);
      chk("rsta_wdata", io_mem_Wdata, 64'd0);

      // Reset in RESP drops the response
      io_mem_Rdata = 64'h89AB_CDEF_0000_0000;
      issue(64'h8000_0004, 64'h0, 1'b0, 2'd2, 1'b1);
      tick();
      chk("lw_rdata", io_resp_rdata, 64'hFFFF_FFFF_89AB_CDEF);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rstr_resp", {63'b0, io_resp_valid}, 64'd0);
      chk("rstr_ready", {63'b0, io_req_ready}, 64'd1);

      // Address wrap near 2^64: store half at the top byte pair
      issue(64'hFFFF_FFFF_FFFF_FFFE, 64'hCAFE, 1'b1, 2'd1, 1'b0);
      chk("wrap_waddr", io_mem_Waddr, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("wrap_wmask", {56'b0, io_mem_Wmask}, 64'hC0);
      chk("wrap_wdata", io_mem_Wdata, 64'hCAFE_0000_0000_0000);
      chk("wrap_wen", {63'b0, io_mem_Write_en}, 64'd1);
      io_resp_ready = 1'b1;
      tick();
      tick();
      io_resp_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
